// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants for the multi-port register file.
//   - load-alignment mode codes driven on ld_mode
//   - CP0 register numbers / selects for Status, Cause, EPC
//   - Status / Cause bit positions and exception codes
//   - exception FSM state type
package regfile_mp_pkg;

    localparam logic [2:0] LD_WORD   = 3'd0;
    localparam logic [2:0] LD_BYTE_S = 3'd1;
    localparam logic [2:0] LD_BYTE_U = 3'd2;
    localparam logic [2:0] LD_HALF_S = 3'd3;
    localparam logic [2:0] LD_HALF_U = 3'd4;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [2:0] CP0_SEL0   = 3'd0;

    localparam int STATUS_EXL    = 1;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;

    localparam int LINK_REG = 31;

    typedef enum logic {
        EXC_NORMAL = 1'b0,
        EXC_ACTIVE = 1'b1
    } exc_state_e;

endpackage

// File: rtl/regfile_mp_ldalign.sv
// regfile_mp_ldalign: combinational load-data alignment for GPR writes.
//   wdata    in  raw write data (word as fetched from memory)
//   ld_mode  in  LD_* code; unknown codes (5-7) pass the word through
//   addr_lo  in  low address bits: byte lane = addr_lo, half lane = addr_lo[1]
//   wdata_al out lane-selected, sign/zero-extended value
module regfile_mp_ldalign
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        ld_mode,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] wdata_al
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = wdata[7:0];
            2'd1:    byte_v = wdata[15:8];
            2'd2:    byte_v = wdata[23:16];
            default: byte_v = wdata[31:24];
        endcase
        half_v = addr_lo[1] ? wdata[31:16] : wdata[15:0];

        case (ld_mode)
            LD_BYTE_S: wdata_al = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BYTE_U: wdata_al = {{(DATA_W-8){1'b0}}, byte_v};
            LD_HALF_S: wdata_al = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HALF_U: wdata_al = {{(DATA_W-16){1'b0}}, half_v};
            default:   wdata_al = wdata;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: MIPS-style GPR file with NRP read ports, HI/LO, and a minimal
// CP0 (Status/Cause/EPC) with a two-state exception FSM.
//   clk, rst_n                 clock (rising), async active-low reset
//   ra / rdata                 packed read addresses / data, port k at k*AW / k*DATA_W
//   we, wa, wdata              GPR write; data aligned by ld_mode / ld_addr_lo
//   link_we, link_pc           r31 <= link_pc + 8 (wins over we to r31)
//   hilo_we, hi_wdata, lo_wdata  bit1 writes HI, bit0 writes LO
//   cp0_we/waddr/wsel/wdata    CP0 write; cp0_raddr/rsel -> cp0_rdata (comb)
//   exc_req, exc_code, exc_pc  exception entry; eret returns
//   hi, lo, epc, exl           architectural state outputs
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle GPR and
// HI/LO writes to the read outputs.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    parameter  int NRP    = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRP*AW-1:0]     ra,
    output logic [NRP*DATA_W-1:0] rdata,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [2:0]            ld_mode,
    input  logic [1:0]            ld_addr_lo,
    input  logic                  link_we,
    input  logic [DATA_W-1:0]     link_pc,
    input  logic [1:0]            hilo_we,
    input  logic [DATA_W-1:0]     hi_wdata,
    input  logic [DATA_W-1:0]     lo_wdata,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [2:0]            cp0_wsel,
    input  logic [DATA_W-1:0]     cp0_wdata,
    input  logic [4:0]            cp0_raddr,
    input  logic [2:0]            cp0_rsel,
    output logic [DATA_W-1:0]     cp0_rdata,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [DATA_W-1:0]     exc_pc,
    input  logic                  eret,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic [DATA_W-1:0]     epc,
    output logic                  exl
);

    // Write gate: stays low through the clock edge on which reset is
    // released, so writes presented on that edge (or during reset) are lost
    // regardless of how rst_n and clk are ordered.
    logic wr_ok_q, wr_ok_d;

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] gpr_d [NREG];
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
    exc_state_e        state_q, state_d;
    logic [DATA_W-1:0] wdata_al;

    regfile_mp_ldalign #(.DATA_W(DATA_W)) u_ldalign (
        .wdata    (wdata),
        .ld_mode  (ld_mode),
        .addr_lo  (ld_addr_lo),
        .wdata_al (wdata_al)
    );

    always_comb begin
        wr_ok_d = 1'b1;

        gpr_d = gpr_q;
        if (wr_ok_q) begin
            if (we) gpr_d[wa] = wdata_al;
            if (link_we) gpr_d[LINK_REG] = link_pc + DATA_W'(8);
        end
        gpr_d[0] = '0;

        hi_d = (wr_ok_q && hilo_we[1]) ? hi_wdata : hi_q;
        lo_d = (wr_ok_q && hilo_we[0]) ? lo_wdata : lo_q;
    end

    // CP0 next state. Applied lowest priority first so exc_req, then eret,
    // overwrite whatever cp0_we did to the registers they own. Status.EXL and
    // the FSM state are always updated together.
    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        state_d  = state_q;
        if (wr_ok_q) begin
            if (cp0_we && cp0_wsel == CP0_SEL0) begin
                case (cp0_waddr)
                    CP0_STATUS: begin
                        status_d = cp0_wdata;
                        state_d  = cp0_wdata[STATUS_EXL] ? EXC_ACTIVE : EXC_NORMAL;
                    end
                    CP0_CAUSE: cause_d = cp0_wdata;
                    CP0_EPC:   epc_d   = cp0_wdata;
                    default:   ;
                endcase
            end
            if (eret && state_q == EXC_ACTIVE) begin
                status_d             = status_q;
                status_d[STATUS_EXL] = 1'b0;
                state_d              = EXC_NORMAL;
            end
            if (exc_req) begin
                status_d             = status_q;
                status_d[STATUS_EXL] = 1'b1;
                cause_d              = cause_q;
                cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;
                // nested exception keeps the original return address
                epc_d                = (state_q == EXC_NORMAL) ? exc_pc : epc_q;
                state_d              = EXC_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ok_q  <= 1'b0;
            gpr_q    <= '{default: '0};
            hi_q     <= '0;
            lo_q     <= '0;
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            state_q  <= EXC_NORMAL;
        end else begin
            wr_ok_q  <= wr_ok_d;
            gpr_q    <= gpr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        if (cp0_rsel == CP0_SEL0) begin
            case (cp0_raddr)
                CP0_STATUS: cp0_rdata = status_q;
                CP0_CAUSE:  cp0_rdata = cause_q;
                CP0_EPC:    cp0_rdata = epc_q;
                default:    cp0_rdata = '0;
            endcase
        end
    end

    assign epc = epc_q;
    assign exl = (state_q == EXC_ACTIVE);

    // gpr_d already carries link-over-we priority and a hard-zero r0, so
    // forwarding is simply a read of the next-state array.
    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[k*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
        assign rdata[k*DATA_W +: DATA_W] = gpr_d[addr];
`else
        assign rdata[k*DATA_W +: DATA_W] = gpr_q[addr];
`endif
    end

`ifdef REGFILE_MP_BYPASS_EN
    assign hi = hi_d;
    assign lo = lo_d;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// Table of load-alignment write/read vectors checked through a scoreboard
// queue, followed by hand-written sequences for link/HI/LO, bypass, the
// exception FSM, CP0 priority and asynchronous reset.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRP*AW-1:0] ra;
    logic [NRP*DW-1:0] rdata;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wdata;
    logic [2:0]        ld_mode;
    logic [1:0]        ld_addr_lo;
    logic              link_we;
    logic [DW-1:0]     link_pc;
    logic [1:0]        hilo_we;
    logic [DW-1:0]     hi_wdata, lo_wdata;
    logic              cp0_we;
    logic [4:0]        cp0_waddr;
    logic [2:0]        cp0_wsel;
    logic [DW-1:0]     cp0_wdata;
    logic [4:0]        cp0_raddr;
    logic [2:0]        cp0_rsel;
    logic [DW-1:0]     cp0_rdata;
    logic              exc_req;
    logic [4:0]        exc_code;
    logic [DW-1:0]     exc_pc;
    logic              eret;
    logic [DW-1:0]     hi, lo, epc;
    logic              exl;

    regfile_mp #(.DATA_W(DW), .NREG(32), .NRP(NRP)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata),
        .we(we), .wa(wa), .wdata(wdata), .ld_mode(ld_mode), .ld_addr_lo(ld_addr_lo),
        .link_we(link_we), .link_pc(link_pc),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rsel(cp0_rsel), .cp0_rdata(cp0_rdata),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .eret(eret),
        .hi(hi), .lo(lo), .epc(epc), .exl(exl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  mode;
        logic [1:0]  lo;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } sb_t;

    vec_t vt [12];
    sb_t  sbq [$];
    sb_t  e;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // one clock edge, then settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [4:0] a1, input logic [4:0] a0);
        ra = {a1, a0};
        #1;
    endtask

    initial begin
        vt[0]  = '{5'd5,  32'h1234_5678, LD_WORD,   2'd0, 32'h1234_5678};
        vt[1]  = '{5'd0,  32'hFFFF_FFFF, LD_WORD,   2'd0, 32'h0000_0000};
        vt[2]  = '{5'd7,  32'h80F0_7F01, LD_BYTE_S, 2'd2, 32'hFFFF_FFF0};
        vt[3]  = '{5'd7,  32'h80F0_7F01, LD_HALF_U, 2'd2, 32'h0000_80F0};
        vt[4]  = '{5'd8,  32'h80F0_7F01, LD_BYTE_U, 2'd3, 32'h0000_0080};
        vt[5]  = '{5'd8,  32'h80F0_7F01, LD_BYTE_S, 2'd3, 32'hFFFF_FF80};
        vt[6]  = '{5'd10, 32'h80F0_7F01, LD_HALF_S, 2'd0, 32'h0000_7F01};
        vt[7]  = '{5'd10, 32'h80F0_7F01, LD_HALF_S, 2'd2, 32'hFFFF_80F0};
        vt[8]  = '{5'd11, 32'h80F0_7F01, LD_BYTE_U, 2'd1, 32'h0000_007F};
        vt[9]  = '{5'd12, 32'h80F0_7F01, 3'd5,      2'd1, 32'h80F0_7F01};
        vt[10] = '{5'd13, 32'hA5A5_0001, 3'd7,      2'd3, 32'hA5A5_0001};
        vt[11] = '{5'd30, 32'hCAFE_F00D, LD_WORD,   2'd0, 32'hCAFE_F00D};

        rst_n = 1'b0; ra = '0;
        we = 1'b1; wa = 5'd5; wdata = 32'hFFFF_FFFF; ld_mode = LD_WORD; ld_addr_lo = 2'd0;
        link_we = 1'b1; link_pc = 32'h1000; hilo_we = 2'b11; hi_wdata = 32'h77; lo_wdata = 32'h66;
        cp0_we = 1'b1; cp0_waddr = CP0_STATUS; cp0_wsel = 3'd0; cp0_wdata = 32'h2;
        cp0_raddr = CP0_STATUS; cp0_rsel = 3'd0;
        exc_req = 1'b0; exc_code = '0; exc_pc = '0; eret = 1'b0;

        // writes held during reset must not land
        repeat (2) tick();
        rd2(5'd31, 5'd5);
        chk("rst_r5", rdata[31:0], 32'h0);
        chk("rst_r31", rdata[63:32], 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_exl", {31'h0, exl}, 32'h0);
        chk("rst_status", cp0_rdata, 32'h0);

        // release coincident with an edge that still presents a write
        link_we = 1'b0; hilo_we = 2'b00; cp0_we = 1'b0;
        wa = 5'd6; wdata = 32'h55;
        @(posedge clk);
        rst_n = 1'b1;
        #1;
        we = 1'b0;
        tick();
        rd2(5'd0, 5'd6);
        chk("release_edge_r6", rdata[31:0], 32'h0);

        // table: write, then read back on both ports through the scoreboard
        for (int i = 0; i < 12; i++) begin
            we = 1'b1; wa = vt[i].wa; wdata = vt[i].wd;
            ld_mode = vt[i].mode; ld_addr_lo = vt[i].lo;
            sbq.push_back('{vt[i].wa, vt[i].exp});
            tick();
            we = 1'b0;
            e = sbq.pop_front();
            rd2(e.addr, e.addr);
            chk($sformatf("vec%0d_p0", i), rdata[31:0], e.exp);
            chk($sformatf("vec%0d_p1", i), rdata[63:32], e.exp);
        end
        ld_mode = LD_WORD; ld_addr_lo = 2'd0;

        // bypass vs. stored value
        we = 1'b1; wa = 5'd9; wdata = 32'h1111; tick();
        wdata = 32'hDEAD_BEEF;
        rd2(5'd9, 5'd5);
`ifdef REGFILE_MP_BYPASS_EN
        chk("same_cycle_r9", rdata[63:32], 32'hDEAD_BEEF);
`else
        chk("same_cycle_r9", rdata[63:32], 32'h0000_1111);
`endif
        chk("same_cycle_r5", rdata[31:0], 32'h1234_5678);
        tick();
        we = 1'b0;
        #1;
        chk("after_edge_r9", rdata[63:32], 32'hDEAD_BEEF);

        // link beats we to r31; HI/LO commit the same cycle
        we = 1'b1; wa = 5'd31; wdata = 32'h11;
        link_we = 1'b1; link_pc = 32'h100;
        hilo_we = 2'b11; hi_wdata = 32'hA; lo_wdata = 32'hB;
        tick();
        we = 1'b0; link_we = 1'b0; hilo_we = 2'b00;
        rd2(5'd31, 5'd31);
        chk("link_r31", rdata[31:0], 32'h108);
        chk("hi_A", hi, 32'hA);
        chk("lo_B", lo, 32'hB);
        we = 1'b1; wa = 5'd4; wdata = 32'h44;
        link_we = 1'b1; link_pc = 32'h200;
        hilo_we = 2'b10; hi_wdata = 32'hC; lo_wdata = 32'hD;
        tick();
        we = 1'b0; link_we = 1'b0; hilo_we = 2'b00;
        rd2(5'd31, 5'd4);
        chk("link_other_r4", rdata[31:0], 32'h44);
        chk("link2_r31", rdata[63:32], 32'h208);
        chk("hi_only_hi", hi, 32'hC);
        chk("hi_only_lo", lo, 32'hB);

        // exception entry, nested exception, eret
        exc_req = 1'b1; exc_code = EXC_SYSCALL; exc_pc = 32'h0040_0100;
        tick();
        exc_req = 1'b0;
        cp0_raddr = CP0_CAUSE; #1;
        chk("exc_exl", {31'h0, exl}, 32'h1);
        chk("exc_epc", epc, 32'h0040_0100);
        chk("exc_cause", cp0_rdata, 32'h20);
        cp0_raddr = CP0_STATUS; #1;
        chk("exc_status", cp0_rdata, 32'h2);
        exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h0040_0200;
        tick();
        exc_req = 1'b0;
        cp0_raddr = CP0_CAUSE; #1;
        chk("nest_epc", epc, 32'h0040_0100);
        chk("nest_cause", cp0_rdata, 32'h30);
        chk("nest_exl", {31'h0, exl}, 32'h1);
        eret = 1'b1; tick(); eret = 1'b0;
        cp0_raddr = CP0_STATUS; #1;
        chk("eret_exl", {31'h0, exl}, 32'h0);
        chk("eret_status", cp0_rdata, 32'h0);
        eret = 1'b1; tick(); eret = 1'b0;
        chk("eret_normal_exl", {31'h0, exl}, 32'h0);

        // cp0_we to Status drives the FSM; eret outranks it the same cycle
        cp0_we = 1'b1; cp0_waddr = CP0_STATUS; cp0_wdata = 32'h2;
        tick();
        cp0_we = 1'b0;
        chk("cp0w_exl", {31'h0, exl}, 32'h1);
        cp0_we = 1'b1; cp0_wdata = 32'h3; eret = 1'b1;
        tick();
        cp0_we = 1'b0; eret = 1'b0;
        chk("eret_over_cp0w_exl", {31'h0, exl}, 32'h0);
        chk("eret_over_cp0w_status", cp0_rdata, 32'h0);

        // exc_req outranks a same-cycle EPC write
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h500;
        cp0_we = 1'b1; cp0_waddr = CP0_EPC; cp0_wdata = 32'hBAD;
        tick();
        exc_req = 1'b0; cp0_we = 1'b0;
        chk("exc_over_cp0w_epc", epc, 32'h500);

        // unimplemented CP0 locations
        cp0_we = 1'b1; cp0_waddr = 5'd9; cp0_wdata = 32'hFFFF_FFFF;
        tick();
        cp0_we = 1'b0;
        cp0_raddr = 5'd9; #1;
        chk("cp0_unimpl", cp0_rdata, 32'h0);
        cp0_raddr = CP0_STATUS; cp0_rsel = 3'd1; #1;
        chk("cp0_sel1", cp0_rdata, 32'h0);
        cp0_rsel = 3'd0;

        // asynchronous reset in the middle of an exception
        we = 1'b1; wa = 5'd3; wdata = 32'h33;
        tick();
        we = 1'b0;
        rd2(5'd0, 5'd3);
        chk("pre_rst_r3", rdata[31:0], 32'h33);
        chk("pre_rst_exl", {31'h0, exl}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_exl", {31'h0, exl}, 32'h0);
        chk("async_epc", epc, 32'h0);
        chk("async_r3", rdata[31:0], 32'h0);
        chk("async_hi", hi, 32'h0);
        chk("async_status", cp0_rdata, 32'h0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
